alu_core: RTL and testbench

Parameterised combinational ALU with one registered sticky error flag. It takes two `width`-bit operands, a carry/borrow input and a 4-bit opcode, and produces a result plus carry, borrow, signed-overflow and invalid-opcode flags in the same cycle. It is the execute-stage datapath of the 3-stage pipeline, and the pipeline registers its result downstream.

---
 rtl/alu_core_if.sv | 26 ++
 rtl/alu_core.sv | 116 +++++++++++
 tb/tb_alu_core.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// alu_core_if: operand/opcode bundle into the ALU and result/flag bundle out; no handshake, always ready.
// master drives operands and consumes results; slave is the ALU side.
interface alu_core_if #(
   parameter int width = 8
);
   logic [width-1:0] a;
   logic [width-1:0] b;
   logic             c_in;
   logic [3:0]       op;
   logic [width-1:0] y;
   logic             c_out;
   logic             overflow;
   logic             borrow;
   logic             invalid_op;
   logic             err_sticky;

   modport master (
      output a, b, c_in, op,
      input  y, c_out, overflow, borrow, invalid_op, err_sticky
   );

   modport slave (
      input  a, b, c_in, op,
      output y, c_out, overflow, borrow, invalid_op, err_sticky
   );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU, zero-cycle result/flags, always ready (no backpressure); only err_sticky is registered.
// Opcodes 11-14 (shift/rotate) exist only when ALU_CORE_SHIFT_ROT_EN is defined, otherwise they decode as reserved.
module alu_core #(
   parameter int width = 8
) (
   input  logic        clk,
   input  logic        reset,
   alu_core_if.slave   alu
);
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_NAND = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_XNOR = 4'd8;
   localparam logic [3:0] OP_INC  = 4'd9;
   localparam logic [3:0] OP_DEC  = 4'd10;
`ifdef ALU_CORE_SHIFT_ROT_EN
   localparam logic [3:0] OP_SHL  = 4'd11;
   localparam logic [3:0] OP_SHR  = 4'd12;
   localparam logic [3:0] OP_ROL  = 4'd13;
   localparam logic [3:0] OP_ROR  = 4'd14;
`endif

   localparam int          MSB     = width - 1;
   localparam logic [MSB:0] MAX_POS = {1'b0, {(width-1){1'b1}}};
   localparam logic [MSB:0] MIN_NEG = {1'b1, {(width-1){1'b0}}};
   localparam logic [MSB:0] ONE     = {{(width-1){1'b0}}, 1'b1};

   logic [width:0] w_sum;
   logic [width:0] w_diff;
   logic [MSB:0]   w_y;
   logic           w_c_out;
   logic           w_overflow;
   logic           w_borrow;
   logic           w_invalid;
   logic           r_err_sticky;

   // One extra bit: carry for ADD, and for SUB it goes high exactly when a < b + c_in.
   assign w_sum  = {1'b0, alu.a} + {1'b0, alu.b} + {{width{1'b0}}, alu.c_in};
   assign w_diff = {1'b0, alu.a} - {1'b0, alu.b} - {{width{1'b0}}, alu.c_in};

   always_comb begin
      w_y        = '0;
      w_c_out    = 1'b0;
      w_overflow = 1'b0;
      w_borrow   = 1'b0;
      w_invalid  = 1'b0;
      case (alu.op)
         OP_ADD: begin
            w_y        = w_sum[MSB:0];
            w_c_out    = w_sum[width];
            w_overflow = (alu.a[MSB] == alu.b[MSB]) && (w_sum[MSB] != alu.a[MSB]);
         end
         OP_SUB: begin
            w_y        = w_diff[MSB:0];
            w_borrow   = w_diff[width];
            w_c_out    = ~w_diff[width];
            w_overflow = (alu.a[MSB] != alu.b[MSB]) && (w_diff[MSB] != alu.a[MSB]);
         end
         OP_AND:  w_y = alu.a & alu.b;
         OP_OR:   w_y = alu.a | alu.b;
         OP_XOR:  w_y = alu.a ^ alu.b;
         OP_NOT:  w_y = ~alu.a;
         OP_NAND: w_y = ~(alu.a & alu.b);
         OP_NOR:  w_y = ~(alu.a | alu.b);
         OP_XNOR: w_y = ~(alu.a ^ alu.b);
         OP_INC: begin
            w_y        = alu.a + ONE;
            w_c_out    = &alu.a;
            w_overflow = (alu.a == MAX_POS);
         end
         OP_DEC: begin
            w_y        = alu.a - ONE;
            w_borrow   = (alu.a == '0);
            w_overflow = (alu.a == MIN_NEG);
         end
`ifdef ALU_CORE_SHIFT_ROT_EN
         OP_SHL: begin
            w_y     = {alu.a[MSB-1:0], 1'b0};
            w_c_out = alu.a[MSB];
         end
         OP_SHR: begin
            w_y     = {1'b0, alu.a[MSB:1]};
            w_c_out = alu.a[0];
         end
         OP_ROL: begin
            w_y     = {alu.a[MSB-1:0], alu.a[MSB]};
            w_c_out = alu.a[MSB];
         end
         OP_ROR: begin
            w_y     = {alu.a[0], alu.a[MSB:1]};
            w_c_out = alu.a[0];
         end
`endif
         default: w_invalid = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_err_sticky <= 1'b0;
      else
         r_err_sticky <= r_err_sticky | w_invalid | w_overflow;
   end

   assign alu.y          = w_y;
   assign alu.c_out      = w_c_out;
   assign alu.overflow   = w_overflow;
   assign alu.borrow     = w_borrow;
   assign alu.invalid_op = w_invalid;
   assign alu.err_sticky = r_err_sticky;
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed stimulus for alu_core with a queue scoreboard of expected results and flags.
module tb_alu_core;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] y;
      logic         c_out;
      logic         overflow;
      logic         borrow;
      logic         invalid_op;
   } exp_t;

   logic   clk;
   logic   reset;
   int     checks;
   int     errors;
   exp_t   exp_q[$];
   string  tag_q[$];

   alu_core_if #(.width(W)) bus ();

   alu_core #(.width(W)) dut (
      .clk   (clk),
      .reset (reset),
      .alu   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [W-1:0] y, input logic c, input logic v,
                               input logic bo, input logic inv);
      exp_t e;
      e.y = y; e.c_out = c; e.overflow = v; e.borrow = bo; e.invalid_op = inv;
      return e;
   endfunction

   // Drive one operation, sample on the falling edge, then let the rising edge capture it.
   task automatic apply(input string tag, input logic [3:0] t_op, input logic [W-1:0] t_a,
                        input logic [W-1:0] t_b, input logic t_cin, input exp_t e);
      exp_t  want;
      exp_t  got;
      string t;
      bus.op   = t_op;
      bus.a    = t_a;
      bus.b    = t_b;
      bus.c_in = t_cin;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      got  = {bus.y, bus.c_out, bus.overflow, bus.borrow, bus.invalid_op};
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed y=%h c=%b v=%b b=%b inv=%b expected y=%h c=%b v=%b b=%b inv=%b",
                t, got.y, got.c_out, got.overflow, got.borrow, got.invalid_op,
                want.y, want.c_out, want.overflow, want.borrow, want.invalid_op);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_sticky(input string tag, input logic want);
      checks++;
      assert (bus.err_sticky === want) else begin
         errors++;
         $error("FAIL %s: observed err_sticky=%b expected %b", tag, bus.err_sticky, want);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.op   = 4'd0;
      bus.a    = '0;
      bus.b    = '0;
      bus.c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_sticky("reset_state", 1'b0);
      reset = 1'b0;

      apply("add_5_3",      4'd0, 8'h05, 8'h03, 1'b0, mk(8'h08, 0, 0, 0, 0));
      apply("add_5_3_cin",  4'd0, 8'h05, 8'h03, 1'b1, mk(8'h09, 0, 0, 0, 0));
      apply("add_ff_01",    4'd0, 8'hFF, 8'h01, 1'b0, mk(8'h00, 1, 0, 0, 0));
      apply("sub_3_5",      4'd1, 8'h03, 8'h05, 1'b0, mk(8'hFE, 0, 0, 1, 0));
      apply("sub_5_5_bin",  4'd1, 8'h05, 8'h05, 1'b1, mk(8'hFF, 0, 0, 1, 0));
      apply("sub_9_4",      4'd1, 8'h09, 8'h04, 1'b0, mk(8'h05, 1, 0, 0, 0));
      apply("and",          4'd2, 8'hF0, 8'h0F, 1'b1, mk(8'h00, 0, 0, 0, 0));
      apply("or",           4'd3, 8'hF0, 8'h0F, 1'b0, mk(8'hFF, 0, 0, 0, 0));
      apply("xor",          4'd4, 8'hF0, 8'h0F, 1'b0, mk(8'hFF, 0, 0, 0, 0));
      apply("not",          4'd5, 8'h0F, 8'h0F, 1'b0, mk(8'hF0, 0, 0, 0, 0));
      apply("nand",         4'd6, 8'hF0, 8'h0F, 1'b0, mk(8'hFF, 0, 0, 0, 0));
      apply("nor",          4'd7, 8'hF0, 8'h0F, 1'b0, mk(8'h00, 0, 0, 0, 0));
      apply("xnor",         4'd8, 8'hF0, 8'h0F, 1'b0, mk(8'h00, 0, 0, 0, 0));
      apply("and_mixed",    4'd2, 8'hA5, 8'h3C, 1'b0, mk(8'h24, 0, 0, 0, 0));
      apply("inc_ff",       4'd9, 8'hFF, 8'h00, 1'b1, mk(8'h00, 1, 0, 0, 0));
      apply("dec_00",       4'd10, 8'h00, 8'h00, 1'b1, mk(8'hFF, 0, 0, 1, 0));
      check_sticky("sticky_clean_ops", 1'b0);

      // Reserved opcode: sticky must not show in the error cycle itself, only after its edge.
      bus.op = 4'd15; bus.a = 8'h12; bus.b = 8'h34; bus.c_in = 1'b1;
      @(negedge clk);
      check_sticky("sticky_same_cycle", 1'b0);
      @(posedge clk);
      #1;
      apply("add_after_op15", 4'd0, 8'h05, 8'h03, 1'b0, mk(8'h08, 0, 0, 0, 0));
      check_sticky("sticky_after_op15", 1'b1);
      apply("op15",         4'd15, 8'hFF, 8'hFF, 1'b1, mk(8'h00, 0, 0, 0, 1));
      apply("add_7f_01",    4'd0, 8'h7F, 8'h01, 1'b0, mk(8'h80, 0, 1, 0, 0));
      apply("sub_80_01",    4'd1, 8'h80, 8'h01, 1'b0, mk(8'h7F, 1, 1, 0, 0));
      apply("inc_7f",       4'd9, 8'h7F, 8'h00, 1'b0, mk(8'h80, 0, 1, 0, 0));
      apply("dec_80",       4'd10, 8'h80, 8'h00, 1'b0, mk(8'h7F, 0, 1, 0, 0));
`ifdef ALU_CORE_SHIFT_ROT_EN
      apply("shl_81",       4'd11, 8'h81, 8'h00, 1'b1, mk(8'h02, 1, 0, 0, 0));
      apply("shr_81",       4'd12, 8'h81, 8'h00, 1'b1, mk(8'h40, 1, 0, 0, 0));
      apply("rol_81",       4'd13, 8'h81, 8'h00, 1'b0, mk(8'h03, 1, 0, 0, 0));
      apply("ror_81",       4'd14, 8'h81, 8'h00, 1'b0, mk(8'hC0, 1, 0, 0, 0));
      apply("shl_40",       4'd11, 8'h40, 8'h00, 1'b0, mk(8'h80, 0, 0, 0, 0));
`else
      apply("shl_81",       4'd11, 8'h81, 8'h00, 1'b1, mk(8'h00, 0, 0, 0, 1));
      apply("shr_81",       4'd12, 8'h81, 8'h00, 1'b1, mk(8'h00, 0, 0, 0, 1));
      apply("rol_81",       4'd13, 8'h81, 8'h00, 1'b0, mk(8'h00, 0, 0, 0, 1));
      apply("ror_81",       4'd14, 8'h81, 8'h00, 1'b0, mk(8'h00, 0, 0, 0, 1));
`endif
      check_sticky("sticky_holds", 1'b1);

      // Reset beats a simultaneous overflow; the combinational flags ignore reset.
      reset = 1'b1;
      apply("add_ovf_in_reset", 4'd0, 8'h7F, 8'h01, 1'b0, mk(8'h80, 0, 1, 0, 0));
      check_sticky("sticky_reset_priority", 1'b0);
      reset = 1'b0;
      apply("add_clean_post_reset", 4'd0, 8'h10, 8'h20, 1'b0, mk(8'h30, 0, 0, 0, 0));
      check_sticky("sticky_stays_clear", 1'b0);
      apply("sub_ovf_post_reset", 4'd1, 8'h7F, 8'hFF, 1'b0, mk(8'h80, 0, 1, 1, 0));
      check_sticky("sticky_sets_again", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
